// File: rtl/c64_pot_mouse.sv
// ============================================================================
// c64_pot_mouse -- 1351 mouse / paddle emulation onto SID POTX/POTY and joystick lines
// Rev 1.0
// ============================================================================
`default_nettype none

module c64_pot_mouse #(
    parameter int SHIFT  = 1,
    parameter int WINDOW = 512
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [1:0] port1_mode,
    input  logic [1:0] port2_mode,
    input  logic [1:0] pot_sel,
    input  logic [1:0] mouse_btns,
    input  logic [7:0] mouse_x,
    input  logic [7:0] mouse_y,
    input  logic       mouse_strobe,
    input  logic [7:0] joystick0ax,
    input  logic [7:0] joystick0ay,
    input  logic [7:0] joystick1ax,
    input  logic [7:0] joystick1ay,
    input  logic       joystick_strobe,
    output logic [7:0] pot_x,
    output logic [7:0] pot_y,
    output logic [4:0] mouse_joy1,
    output logic [4:0] mouse_joy2,
    output logic       window_tick
);

    localparam int            CW            = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CW-1:0] C_LAST        = CW'(WINDOW - 1);
    localparam logic [1:0]    C_MODE_MOUSE  = 2'd1;
    localparam logic [1:0]    C_MODE_PADDLE = 2'd2;
    localparam logic [7:0]    C_NO_DEVICE   = 8'hFF;
    localparam logic [7:0]    C_PAD_CENTRE  = 8'h80;

    logic [11:0]   r_acc_x;
    logic [11:0]   r_acc_y;
    logic [7:0]    r_pad0x;
    logic [7:0]    r_pad0y;
    logic [7:0]    r_pad1x;
    logic [7:0]    r_pad1y;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_sh1x;
    logic [7:0]    r_sh1y;
    logic [7:0]    r_sh2x;
    logic [7:0]    r_sh2y;
    logic [7:0]    r_pot_x;
    logic [7:0]    r_pot_y;
    logic [1:0]    r_btns;
    logic [4:0]    r_joy1;
    logic [4:0]    r_joy2;

    logic          w_publish;
    logic [11:0]   w_dx;
    logic [11:0]   w_dy;
    logic [7:0]    w_mouse_x;
    logic [7:0]    w_mouse_y;
    logic [1:0]    w_btns_nxt;
    logic [4:0]    w_joy_btn;
    logic          w_unused_acc;

    function automatic logic [7:0] f_src(
        input logic [1:0] mode,
        input logic [7:0] mouse,
        input logic [7:0] pad
    );
        case (mode)
            C_MODE_MOUSE:  f_src = mouse;
            C_MODE_PADDLE: f_src = pad;
            default:       f_src = C_NO_DEVICE;
        endcase
    endfunction

    // Publish is qualified by reset so the tick stays low while reset is held.
    assign w_publish = ce && (r_cnt == C_LAST) && !reset;

    assign w_dx      = {{4{mouse_x[7]}}, mouse_x};
    assign w_dy      = {{4{mouse_y[7]}}, mouse_y};
    assign w_mouse_x = {1'b0, r_acc_x[SHIFT+5:SHIFT], 1'b0};
    assign w_mouse_y = {1'b0, r_acc_y[SHIFT+5:SHIFT], 1'b0};

    assign w_unused_acc = ^{r_acc_x, r_acc_y};

    // Buttons bypass the window: route the value being latched this cycle.
    assign w_btns_nxt = mouse_strobe ? mouse_btns : r_btns;
    assign w_joy_btn  = {w_btns_nxt[0], 3'b000, w_btns_nxt[1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_x <= 12'd0;
            r_acc_y <= 12'd0;
            r_btns  <= 2'b00;
        end else if (mouse_strobe) begin
            r_acc_x <= r_acc_x + w_dx;
            r_acc_y <= r_acc_y - w_dy;
            r_btns  <= mouse_btns;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pad0x <= C_PAD_CENTRE;
            r_pad0y <= C_PAD_CENTRE;
            r_pad1x <= C_PAD_CENTRE;
            r_pad1y <= C_PAD_CENTRE;
        end else if (joystick_strobe) begin
            r_pad0x <= joystick0ax ^ 8'h80;
            r_pad0y <= joystick0ay ^ 8'h80;
            r_pad1x <= joystick1ax ^ 8'h80;
            r_pad1y <= joystick1ay ^ 8'h80;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_publish) begin
            r_cnt <= '0;
        end else if (ce) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Shadows sample the pre-edge sources, so a strobe in the publish cycle waits a window.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh1x <= C_NO_DEVICE;
            r_sh1y <= C_NO_DEVICE;
            r_sh2x <= C_NO_DEVICE;
            r_sh2y <= C_NO_DEVICE;
        end else if (w_publish) begin
            r_sh1x <= f_src(port1_mode, w_mouse_x, r_pad0x);
            r_sh1y <= f_src(port1_mode, w_mouse_y, r_pad0y);
            r_sh2x <= f_src(port2_mode, w_mouse_x, r_pad1x);
            r_sh2y <= f_src(port2_mode, w_mouse_y, r_pad1y);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pot_x <= C_NO_DEVICE;
            r_pot_y <= C_NO_DEVICE;
        end else begin
            case (pot_sel)
                2'b01: begin
                    r_pot_x <= r_sh1x;
                    r_pot_y <= r_sh1y;
                end
                2'b10: begin
                    r_pot_x <= r_sh2x;
                    r_pot_y <= r_sh2y;
                end
                default: begin
                    r_pot_x <= C_NO_DEVICE;
                    r_pot_y <= C_NO_DEVICE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_joy1 <= 5'd0;
            r_joy2 <= 5'd0;
        end else begin
            r_joy1 <= (port1_mode == C_MODE_MOUSE) ? w_joy_btn : 5'd0;
            r_joy2 <= (port2_mode == C_MODE_MOUSE) ? w_joy_btn : 5'd0;
        end
    end

    assign pot_x       = r_pot_x;
    assign pot_y       = r_pot_y;
    assign mouse_joy1  = r_joy1;
    assign mouse_joy2  = r_joy2;
    assign window_tick = w_publish;

endmodule

`default_nettype wire

// File: tb/tb_c64_pot_mouse.sv
// ============================================================================
// tb_c64_pot_mouse -- directed table plus randomized checks against a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_c64_pot_mouse;

    localparam int SHIFT = 1;
    localparam int W     = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0;
    logic [1:0] port1_mode = 2'd0;
    logic [1:0] port2_mode = 2'd0;
    logic [1:0] pot_sel = 2'd0;
    logic [1:0] mouse_btns = 2'd0;
    logic [7:0] mouse_x = 8'd0;
    logic [7:0] mouse_y = 8'd0;
    logic       mouse_strobe = 1'b0;
    logic [7:0] joystick0ax = 8'd0;
    logic [7:0] joystick0ay = 8'd0;
    logic [7:0] joystick1ax = 8'd0;
    logic [7:0] joystick1ay = 8'd0;
    logic       joystick_strobe = 1'b0;
    logic [7:0] pot_x;
    logic [7:0] pot_y;
    logic [4:0] mouse_joy1;
    logic [4:0] mouse_joy2;
    logic       window_tick;

    always #5 clk = ~clk;

    c64_pot_mouse #(.SHIFT(SHIFT), .WINDOW(W)) dut (
        .clk(clk), .reset(reset), .ce(ce),
        .port1_mode(port1_mode), .port2_mode(port2_mode), .pot_sel(pot_sel),
        .mouse_btns(mouse_btns), .mouse_x(mouse_x), .mouse_y(mouse_y),
        .mouse_strobe(mouse_strobe),
        .joystick0ax(joystick0ax), .joystick0ay(joystick0ay),
        .joystick1ax(joystick1ax), .joystick1ay(joystick1ay),
        .joystick_strobe(joystick_strobe),
        .pot_x(pot_x), .pot_y(pot_y),
        .mouse_joy1(mouse_joy1), .mouse_joy2(mouse_joy2),
        .window_tick(window_tick)
    );

    int n_checks = 0;
    int n_err    = 0;
    int ce_count = 0;
    int ce_at_tick = 0;

    // Behavioural model: integer accumulators, arrays for pads/shadows (p1x,p1y,p2x,p2y).
    int         m_acc_x = 0;
    int         m_acc_y = 0;
    logic [7:0] m_pad [4];
    logic [7:0] m_sh  [4];
    int         m_cnt = 0;
    logic [7:0] m_px = 8'hFF;
    logic [7:0] m_py = 8'hFF;
    logic [1:0] m_btns = 2'd0;
    logic [4:0] m_j1 = 5'd0;
    logic [4:0] m_j2 = 5'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mpot(input int acc);
        return 8'(((acc >> SHIFT) % 64) * 2);
    endfunction

    task automatic model_edge();
        bit pub;
        logic [1:0] nb;
        logic [1:0] mode;
        logic [4:0] jb;
        if (reset) begin
            m_acc_x = 0; m_acc_y = 0; m_cnt = 0;
            m_px = 8'hFF; m_py = 8'hFF; m_btns = 2'd0; m_j1 = 5'd0; m_j2 = 5'd0;
            for (int k = 0; k < 4; k++) begin
                m_pad[k] = 8'h80;
                m_sh[k]  = 8'hFF;
            end
        end else begin
            pub = ce && (m_cnt == W - 1);
            if (pot_sel == 2'b01) begin m_px = m_sh[0]; m_py = m_sh[1]; end
            else if (pot_sel == 2'b10) begin m_px = m_sh[2]; m_py = m_sh[3]; end
            else begin m_px = 8'hFF; m_py = 8'hFF; end
            if (pub) begin
                for (int p = 0; p < 2; p++) begin
                    mode = (p == 0) ? port1_mode : port2_mode;
                    if (mode == 2'd1) begin
                        m_sh[2*p] = mpot(m_acc_x); m_sh[2*p+1] = mpot(m_acc_y);
                    end else if (mode == 2'd2) begin
                        m_sh[2*p] = m_pad[2*p]; m_sh[2*p+1] = m_pad[2*p+1];
                    end else begin
                        m_sh[2*p] = 8'hFF; m_sh[2*p+1] = 8'hFF;
                    end
                end
            end
            nb = mouse_strobe ? mouse_btns : m_btns;
            jb = {nb[0], 3'b000, nb[1]};
            m_j1 = (port1_mode == 2'd1) ? jb : 5'd0;
            m_j2 = (port2_mode == 2'd1) ? jb : 5'd0;
            if (mouse_strobe) begin
                m_btns  = mouse_btns;
                m_acc_x = (m_acc_x + int'($signed(mouse_x))) & 4095;
                m_acc_y = (m_acc_y - int'($signed(mouse_y))) & 4095;
            end
            if (joystick_strobe) begin
                m_pad[0] = joystick0ax ^ 8'h80; m_pad[1] = joystick0ay ^ 8'h80;
                m_pad[2] = joystick1ax ^ 8'h80; m_pad[3] = joystick1ay ^ 8'h80;
            end
            if (pub) m_cnt = 0;
            else if (ce) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic step(input bit force_ce, output bit tick);
        bit exp_tick;
        ce = force_ce ? 1'b1 : ($urandom_range(0, 3) != 0);
        @(negedge clk);
        exp_tick = !reset && ce && (m_cnt == W - 1);
        chk("window_tick", 32'(window_tick), 32'(exp_tick));
        tick = exp_tick;
        if (ce) ce_count++;
        if (exp_tick) ce_at_tick = ce_count;
        @(posedge clk);
        model_edge();
        #1;
        chk("pot_x", 32'(pot_x), 32'(m_px));
        chk("pot_y", 32'(pot_y), 32'(m_py));
        chk("mouse_joy1", 32'(mouse_joy1), 32'(m_j1));
        chk("mouse_joy2", 32'(mouse_joy2), 32'(m_j2));
    endtask

    // Runs through the next publish plus one clock so the pots reflect it.
    task automatic wait_tick();
        bit t;
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 8 * W; k++) begin
            step(1'b0, t);
            if (t) begin
                seen = 1'b1;
                break;
            end
        end
        chk("tick_timeout", 32'(seen), 32'd1);
        step(1'b0, t);
    endtask

    typedef struct {
        logic [7:0] mx;
        logic [7:0] my;
        logic [7:0] ex;
        logic [7:0] ey;
    } vec_t;

    vec_t tbl [7];

    initial begin
        bit t;
        int c0;

        tbl[0] = '{8'd10,  8'hFC, 8'h0A, 8'h04};
        tbl[1] = '{8'd6,   8'd0,  8'h10, 8'h04};
        tbl[2] = '{8'hEE,  8'd0,  8'h7E, 8'h04};
        tbl[3] = '{8'd4,   8'd0,  8'h02, 8'h04};
        tbl[4] = '{8'd0,   8'd10, 8'h02, 8'h7A};
        tbl[5] = '{8'd127, 8'd0,  8'h00, 8'h7A};
        tbl[6] = '{8'h80,  8'h80, 8'h00, 8'h7A};

        // Reset state
        reset = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b0, t);
        chk("reset_pot_x", 32'(pot_x), 32'hFF);
        chk("reset_pot_y", 32'(pot_y), 32'hFF);
        chk("reset_joy1", 32'(mouse_joy1), 32'd0);
        chk("reset_joy2", 32'(mouse_joy2), 32'd0);

        reset = 1'b0; port1_mode = 2'd1; pot_sel = 2'b01;
        wait_tick();
        chk("first_tick_pot_x", 32'(pot_x), 32'h00);
        chk("first_tick_pot_y", 32'(pot_y), 32'h00);

        // Cumulative deltas, including wrap
        for (int i = 0; i < 7; i++) begin
            mouse_x = tbl[i].mx; mouse_y = tbl[i].my; mouse_strobe = 1'b1;
            step(1'b0, t);
            mouse_strobe = 1'b0;
            wait_tick();
            chk("tbl_pot_x", 32'(pot_x), 32'(tbl[i].ex));
            chk("tbl_pot_y", 32'(pot_y), 32'(tbl[i].ey));
        end

        // Strobe coinciding with the publish cycle
        for (int k = 0; k < 8 * W; k++) begin
            if (m_cnt == W - 1) break;
            step(1'b0, t);
        end
        mouse_x = 8'd20; mouse_y = 8'd0; mouse_strobe = 1'b1;
        step(1'b1, t);
        mouse_strobe = 1'b0;
        chk("boundary_is_tick", 32'(t), 32'd1);
        c0 = ce_count;
        step(1'b0, t);
        chk("boundary_not_published", 32'(pot_x), 32'h00);
        wait_tick();
        chk("boundary_ce_distance", 32'(ce_at_tick - c0), 32'(W));
        chk("boundary_published_x", 32'(pot_x), 32'h14);
        chk("boundary_published_y", 32'(pot_y), 32'h7A);

        // Paddles on port 2
        port2_mode = 2'd2; pot_sel = 2'b10;
        joystick1ax = 8'h80; joystick1ay = 8'h7F; joystick_strobe = 1'b1;
        step(1'b0, t);
        joystick_strobe = 1'b0;
        wait_tick();
        chk("paddle_pot_x", 32'(pot_x), 32'h00);
        chk("paddle_pot_y", 32'(pot_y), 32'hFF);
        pot_sel = 2'b00;
        step(1'b0, t);
        chk("nosel_pot_x", 32'(pot_x), 32'hFF);
        chk("nosel_pot_y", 32'(pot_y), 32'hFF);

        // Buttons
        port1_mode = 2'd0; port2_mode = 2'd1;
        mouse_btns = 2'b11; mouse_x = 8'd0; mouse_y = 8'd0; mouse_strobe = 1'b1;
        step(1'b0, t);
        mouse_strobe = 1'b0;
        chk("btn_joy2", 32'(mouse_joy2), 32'h11);
        chk("btn_joy1", 32'(mouse_joy1), 32'd0);
        port2_mode = 2'd0;
        step(1'b0, t);
        chk("btn_mode_off_joy2", 32'(mouse_joy2), 32'd0);

        // Randomized traffic, including occasional mid-window reset
        for (int n = 0; n < 600; n++) begin
            reset           = ($urandom_range(0, 99) == 0);
            mouse_strobe    = ($urandom_range(0, 3) == 0);
            joystick_strobe = ($urandom_range(0, 5) == 0);
            mouse_x         = 8'($urandom);
            mouse_y         = 8'($urandom);
            mouse_btns      = 2'($urandom);
            joystick0ax     = 8'($urandom);
            joystick0ay     = 8'($urandom);
            joystick1ax     = 8'($urandom);
            joystick1ay     = 8'($urandom);
            if ($urandom_range(0, 49) == 0) port1_mode = 2'($urandom);
            if ($urandom_range(0, 49) == 0) port2_mode = 2'($urandom);
            if ($urandom_range(0, 19) == 0) pot_sel    = 2'($urandom);
            step(1'b0, t);
        end
        reset = 1'b0; mouse_strobe = 1'b0; joystick_strobe = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/c64_pot_mouse.md
# c64_pot_mouse

Converts the HID stage's USB mouse and analog-stick events into the 8-bit POTX/POTY values that the SID samples. It emulates a Commodore 1351 proportional mouse or a paddle pair on either control port. It sits between the HID block, which supplies the mouse and joystick outputs and strobes, and the SID POT inputs. It also supplies the mouse buttons as joystick lines for the port mux.

## Interface
- `SHIFT`, default 1: mouse delta down-scale; pot position = accumulator bits [SHIFT+5:SHIFT].
- `WINDOW`, default 512: `ce` pulses per SID pot-sample window.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `ce`  in  1  phi2 clock enable, 1 pulse per C64 cycle.
- `port1_mode`  in  2  0 = none, 1 = 1351 mouse, 2 = paddles from `joystick0ax`/`joystick0ay`, 3 = none.
- `port2_mode`  in  2  same encoding; paddles from `joystick1ax`/`joystick1ay`.
- `pot_sel`  in  2  CIA1 PA[7:6]: 01 = port1, 10 = port2, else no device.
- `mouse_btns`  in  2  bit0 left, bit1 right, active-high.
- `mouse_x`  in  8  signed delta, +right.
- `mouse_y`  in  8  signed delta, +down (USB convention).
- `mouse_strobe`  in  1  one-cycle: `mouse_x`/`mouse_y`/`mouse_btns` valid.
- `joystick0ax`, `joystick0ay`, `joystick1ax`, `joystick1ay`  in  8 each  signed stick axes.
- `joystick_strobe`  in  1  one-cycle: axes valid.
- `pot_x`  out  8  value presented to SID POTX.
- `pot_y`  out  8  value presented to SID POTY.
- `mouse_joy1`  out  5  port1 joystick lines {fire, right, left, down, up}, active-high.
- `mouse_joy2`  out  5  same layout for port2.
- `window_tick`  out  1  one-cycle pulse at each publish.

## Operation
- **Accumulators.** `acc_x` and `acc_y` are 12-bit and wrap modulo 4096; there is no saturation.
  - On `mouse_strobe`: `acc_x += sext(mouse_x)` and `acc_y -= sext(mouse_y)`. Y is inverted so that up is positive.
  - Both accumulators update in the same cycle.
- **Mouse pot value.** pot = {1'b0, acc[SHIFT+5:SHIFT], 1'b0}, so the range is 0x00..0x7E, even values only.
- **Paddle staging.** On `joystick_strobe`, each axis is staged as `axis ^ 8'h80`, giving -128→0x00, 0→0x80, 127→0xFF.
- **Window counter.** Counts `ce` pulses from 0 to WINDOW-1.
  - At the `ce` where the count equals WINDOW-1, the counter wraps to 0 and a publish occurs.
  - On publish, the per-port shadow registers take their source: mouse value, paddle staging, or 0xFF for modes 0 and 3.
  - `window_tick` is high for that one cycle.
- **Mux.** `pot_x`/`pot_y` are registered from the shadows selected by `pot_sel`; selections 00 and 11 give 0xFF/0xFF. `pot_sel` changes take effect one cycle later and do not wait for a window.
- **Buttons.** In mode 1, the mouse port's `mouse_joy` gets fire = `mouse_btns[0]` and up = `mouse_btns[1]`; all other bits are 0.
  - Buttons latch on `mouse_strobe` and are not windowed.
  - In any mode other than 1, that port's `mouse_joy` is 0.
- **Both ports in mode 1.** Both ports show the same accumulator and buttons.
- **Mode change.** Takes effect at the next publish for the pots and on the next cycle for the buttons. A change does not clear the accumulators.

## Timing
- **Reset values.**
  - `pot_x` = `pot_y` = 0xFF.
  - Shadows 0xFF.
  - Accumulators 0.
  - Paddle staging 0x80.
  - `mouse_joy1` = `mouse_joy2` = 0.
  - `window_tick` 0.
  - Window counter 0.
- **Reset mid-window.** Restarts the counter at 0; the next publish comes WINDOW `ce` pulses later.
- **Strobe-to-shadow latency.** A strobe is visible in the shadow at the first publish strictly after the strobe cycle.
- **Strobe in the publish cycle.** A strobe arriving in the publish cycle itself is not included; it appears at the following publish.
- **Shadow-to-output latency.** `pot_x`/`pot_y` follow the shadows 1 clk after publish.
- **Simultaneous events.** `mouse_strobe` and `joystick_strobe` in the same cycle are both applied.
- **Publish while `ce` is low.** Not possible; publishing is gated by `ce`.
- **Button latency.** `mouse_btns` → `mouse_joy`: 1 clk after `mouse_strobe`.

## Test plan
- **Reset.** Assert reset → `pot_x`/`pot_y` = 0xFF, `mouse_joy1`/`mouse_joy2` = 0. Release, `port1_mode`=1, `pot_sel`=01, no strobes → after the first `window_tick`, `pot_x` = `pot_y` = 0x00.
- **Deltas.** SHIFT=1, `port1_mode`=1. Strobes x=+10, y=-4, then x=+6 → after the next tick, acc_x=16 → `pot_x`=0x10; acc_y=+4 → `pot_y`=0x04.
- **Wrap.** x=-2 from reset → acc_x=0xFFE → `pot_x`=0x7E. Then x=+4 → `pot_x`=0x02.
- **Paddles.** `port2_mode`=2, `pot_sel`=10. `joystick_strobe` with `joystick1ax`=0x80 and `joystick1ay`=0x7F → `pot_x`=0x00, `pot_y`=0xFF after the tick. Then `pot_sel`=00 → 0xFF/0xFF one clk later.
- **Window boundary.**
  - A `mouse_strobe` in the same cycle as `window_tick` is not published.
  - It is published exactly WINDOW `ce` pulses later.
  - Values never change between ticks.
- **Buttons.** `port2_mode`=1, strobe with `btns`=2'b11 → `mouse_joy2`=5'b10001 after 1 clk, `mouse_joy1`=0. Then `port2_mode`=0 → `mouse_joy2`=0.
